// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW SRAM model.
package sram_pkg;

  typedef enum logic {CLEAR, READY} sram_state_e;

  localparam int unsigned MAX_READ_LAT = 2;
  localparam int unsigned MAX_WIDTH    = 4096;

  // Bit-granular merge; callers widen operands to MAX_WIDTH and cast the result back.
  function automatic logic [MAX_WIDTH-1:0] merge_mask(input logic [MAX_WIDTH-1:0] old_word,
                                                      input logic [MAX_WIDTH-1:0] new_word,
                                                      input logic [MAX_WIDTH-1:0] bit_en);
    return (old_word & ~bit_en) | (new_word & bit_en);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// READ_LAT-deep read data/valid pipeline; the last stage drives the SRAM read outputs.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0]    data_q [READ_LAT];
  logic [READ_LAT-1:0] valid_q;

  // Data stages load only on valid so the output holds its last read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < READ_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign data_o  = data_q[READ_LAT-1];
  assign valid_o = valid_q[READ_LAT-1];

endmodule

// File: rtl/sram1rw_param.sv
// Parametrised 1RW SRAM with group write mask, 1/2-cycle read latency and post-reset clear.
// Define SRAM_WRITE_THROUGH_EN to make a same-cycle read+write return the merged word.
module sram1rw_param
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter int unsigned MASK_GRAN  = 8,
  parameter int unsigned READ_LAT   = 1,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                       CE,
  input  logic                       RSTB,
  input  logic                       CSB,
  input  logic                       WEB,
  input  logic                       OEB,
  input  logic [ADDR_W-1:0]          A,
  input  logic [WIDTH-1:0]           I,
  input  logic [WIDTH/MASK_GRAN-1:0] BWEB,
  output logic [WIDTH-1:0]           O,
  output logic                       OV,
  output logic                       BUSY
);

  localparam int unsigned NumGroups = WIDTH / MASK_GRAN;

  if (WIDTH % MASK_GRAN != 0) begin : gen_bad_gran
    $error("WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : gen_bad_lat
    $error("READ_LAT must be 1 or 2");
  end
  if (WIDTH > MAX_WIDTH) begin : gen_bad_width
    $error("WIDTH exceeds MAX_WIDTH");
  end

  logic [WIDTH-1:0]  mem [DEPTH];
  sram_state_e       state_q;
  logic [ADDR_W-1:0] clr_cnt_q;

  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q   <= INIT_CLEAR ? CLEAR : READY;
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_q <= READY;
      clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
    end
  end

  assign BUSY = (state_q == CLEAR);

  logic re, we, addr_ok;
  assign re      = ~CSB & ~OEB & ~BUSY;
  assign we      = ~CSB & ~WEB & ~BUSY;
  // Only reachable when DEPTH is not a power of two.
  assign addr_ok = (32'(A) < DEPTH);

  logic [WIDTH-1:0] bit_en, old_word, merged, rd_word;

  always_comb begin
    bit_en = '0;
    for (int g = 0; g < NumGroups; g++) begin
      bit_en[g*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{~BWEB[g]}};
    end
  end

  assign old_word = addr_ok ? mem[A] : '0;
  assign merged   = WIDTH'(merge_mask(MAX_WIDTH'(old_word), MAX_WIDTH'(I), MAX_WIDTH'(bit_en)));

`ifdef SRAM_WRITE_THROUGH_EN
  assign rd_word = !addr_ok ? '0 : (we ? merged : old_word);
`else
  assign rd_word = old_word;
`endif

  // Array is deliberately not reset; the clear engine zero-fills it instead.
  always_ff @(posedge CE) begin
    if (BUSY) begin
      mem[clr_cnt_q] <= '0;
    end else if (we && addr_ok) begin
      mem[A] <= merged;
    end
  end

  sram_rd_pipe #(
    .WIDTH   (WIDTH),
    .READ_LAT(READ_LAT)
  ) u_rd_pipe (
    .clk_i  (CE),
    .rst_ni (RSTB),
    .valid_i(re),
    .data_i (rd_word),
    .data_o (O),
    .valid_o(OV)
  );

endmodule

// File: tb/tb_sram1rw_param.sv
// Randomised and directed bench for sram1rw_param: a 1024-word/latency-1 instance and a
// 1000-word/latency-2 instance share stimulus and are checked against an array model.
module tb_sram1rw_param;

  logic        CE = 1'b0;
  logic        RSTB = 1'b1;
  logic        CSB = 1'b1, WEB = 1'b1, OEB = 1'b1;
  logic [9:0]  A = '0;
  logic [15:0] I = '0;
  logic [1:0]  BWEB = 2'b11;
  logic [15:0] o0, o1;
  logic        ov0, ov1, busy0, busy1;

  always #5 CE = ~CE;

  sram1rw_param u_dut0 (
    .CE(CE), .RSTB(RSTB), .CSB(CSB), .WEB(WEB), .OEB(OEB), .A(A), .I(I), .BWEB(BWEB),
    .O(o0), .OV(ov0), .BUSY(busy0)
  );

  sram1rw_param #(.DEPTH(1000), .READ_LAT(2)) u_dut1 (
    .CE(CE), .RSTB(RSTB), .CSB(CSB), .WEB(WEB), .OEB(OEB), .A(A), .I(I), .BWEB(BWEB),
    .O(o1), .OV(ov1), .BUSY(busy1)
  );

  int npass = 0, ntotal = 0, cyc = 0;

  // Reference model
  logic [15:0] mem_m [2][1024];
  int          dep [2] = '{1024, 1000};
  int          lat [2] = '{1, 2};
  int          left [2];
  logic [15:0] exp_o [2];
  logic        exp_ov [2];
  logic        pend_v [2];
  logic [15:0] pend_d [2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s@%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_o0"}, o0, exp_o[0]);
    check({tag, "_ov0"}, 16'(ov0), 16'(exp_ov[0]));
    check({tag, "_busy0"}, 16'(busy0), 16'(left[0] > 0));
    check({tag, "_o1"}, o1, exp_o[1]);
    check({tag, "_ov1"}, 16'(ov1), 16'(exp_ov[1]));
    check({tag, "_busy1"}, 16'(busy1), 16'(left[1] > 0));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      left[d]   = dep[d];
      exp_o[d]  = '0;
      exp_ov[d] = 1'b0;
      pend_v[d] = 1'b0;
      pend_d[d] = '0;
      // Whatever the array held, the clear completes before any access is accepted.
      for (int k = 0; k < 1024; k++) mem_m[d][k] = '0;
    end
  endtask

  task automatic model_edge(input logic csb, input logic web, input logic oeb,
                            input logic [9:0] a, input logic [15:0] wd, input logic [1:0] bw);
    bit          busy, re, we, inr;
    logic [15:0] old, mrg, rd;
    if (!RSTB) return;
    for (int d = 0; d < 2; d++) begin
      busy = left[d] > 0;
      re   = !csb && !oeb && !busy;
      we   = !csb && !web && !busy;
      inr  = int'(a) < dep[d];
      old  = inr ? mem_m[d][a] : 16'h0;
      mrg  = old;
      if (!bw[0]) mrg[7:0] = wd[7:0];
      if (!bw[1]) mrg[15:8] = wd[15:8];
      rd = old;
`ifdef SRAM_WRITE_THROUGH_EN
      if (we) rd = mrg;
`endif
      if (!inr) rd = 16'h0;
      if (we && inr) mem_m[d][a] = mrg;
      if (busy) left[d]--;
      if (lat[d] == 1) begin
        exp_ov[d] = re;
        if (re) exp_o[d] = rd;
      end else begin
        exp_ov[d] = pend_v[d];
        if (pend_v[d]) exp_o[d] = pend_d[d];
        pend_v[d] = re;
        pend_d[d] = rd;
      end
    end
  endtask

  // Called at posedge+1; drives inputs, advances one edge, then checks.
  task automatic step(input logic csb, input logic web, input logic oeb,
                      input logic [9:0] a, input logic [15:0] wd, input logic [1:0] bw);
    CSB = csb; WEB = web; OEB = oeb; A = a; I = wd; BWEB = bw;
    @(posedge CE);
    cyc++;
    model_edge(csb, web, oeb, a, wd, bw);
    #1;
    check_all("step");
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b1, 10'd0, 16'h0, 2'b11);
  endtask

  task automatic rand_step();
    logic [9:0] a;
    a = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(995, 1023));
    step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         a, 16'($urandom), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    #1 RSTB = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(posedge CE); #1;
    idle();
    idle();
    RSTB = 1'b1;

    // Clear runs; requests meanwhile must be dropped.
    for (int k = 0; k < 500; k++) rand_step();

    // Async reset mid-clear restarts the whole clear.
    RSTB = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    idle();
    RSTB = 1'b1;
    for (int k = 0; k < 1100 && left[0] > 0; k++) rand_step();
    check("clear_done", 16'(left[0]), 16'h0);

    // Read after clear returns zero.
    step(1'b0, 1'b1, 1'b0, 10'd5, 16'h0, 2'b11);
    check("t1_o", o0, 16'h0000);
    check("t1_ov", 16'(ov0), 16'h1);

    // Group-masked write merge.
    step(1'b0, 1'b0, 1'b1, 10'd3, 16'hBEEF, 2'b00);
    step(1'b0, 1'b0, 1'b1, 10'd3, 16'h1234, 2'b10);
    step(1'b0, 1'b1, 1'b0, 10'd3, 16'h0, 2'b11);
    check("t2_o0", o0, 16'hBE34);
    idle();
    check("t2_o1", o1, 16'hBE34);

    // Back-to-back reads through the latency-2 pipe.
    step(1'b0, 1'b1, 1'b0, 10'd1, 16'h0, 2'b11);
    check("t3_ov1_first", 16'(ov1), 16'h0);
    step(1'b0, 1'b1, 1'b0, 10'd2, 16'h0, 2'b11);
    step(1'b0, 1'b1, 1'b0, 10'd3, 16'h0, 2'b11);
    idle();
    check("t3_last", o1, 16'hBE34);
    idle();
    check("t3_ov1_end", 16'(ov1), 16'h0);

    // Same-edge read and write.
    step(1'b0, 1'b0, 1'b0, 10'd7, 16'hAAAA, 2'b00);
`ifdef SRAM_WRITE_THROUGH_EN
    check("t4_o0", o0, 16'hAAAA);
`else
    check("t4_o0", o0, 16'h0000);
`endif
    idle();

    // Out-of-range address on the 1000-word instance.
    step(1'b0, 1'b0, 1'b1, 10'd1000, 16'h5A5A, 2'b00);
    step(1'b0, 1'b1, 1'b0, 10'd1000, 16'h0, 2'b11);
    check("t6_o0", o0, 16'h5A5A);
    idle();
    check("t6_o1", o1, 16'h0000);
    check("t6_ov1", 16'(ov1), 16'h1);

    for (int k = 0; k < 400; k++) rand_step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
